// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC-source selection logic: default widths,
// pc_sel encodings and the redirect FSM state encoding.
package fetch_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_PRED  = 3'd1,
        SEL_JUMP  = 3'd2,
        SEL_JR    = 3'd3,
        SEL_MISP  = 3'd4,
        SEL_PEND  = 3'd5,
        SEL_RESET = 3'd7
    } pc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Unsigned counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC-source arbiter: picks next_pc by redirect priority, parks redirects
// that arrive during a stall, and counts resolved branches and mispredictions.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [PC_W-1:0]  pc_plus1_F,
    input  logic             branch_F,
    input  logic             prediction_F,
    input  logic [PC_W-1:0]  branch_addr_F,
    input  logic             jump_F,
    input  logic [PC_W-1:0]  jump_addr_F,
    input  logic             jr_D,
    input  logic [PC_W-1:0]  jr_addr_D,
    input  logic             branch_EX,
    input  logic             prediction_EX,
    input  logic             taken_EX,
    input  logic [PC_W-1:0]  branch_addr_EX,
    input  logic [PC_W-1:0]  pc_plus1_EX,
    output logic [PC_W-1:0]  next_pc,
    output logic [2:0]       pc_sel,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    state_e          r_state;
    logic [PC_W-1:0] r_pend_tgt;
    logic            r_pend_misp;

    logic            w_misp;
    logic [PC_W-1:0] w_misp_tgt;
    logic [PC_W-1:0] w_next_pc;
    pc_sel_e         w_sel;
    logic            w_flush_if_id;
    logic            w_flush_id_ex;
    logic            w_br_inc;
    logic            w_misp_inc;

    assign w_misp     = branch_EX & (prediction_EX ^ taken_EX);
    assign w_misp_tgt = taken_EX ? branch_addr_EX : pc_plus1_EX;

    // Under hold the PC ignores next_pc, so the outputs simply idle at SEQ.
    always_comb begin
        w_next_pc     = pc_plus1_F;
        w_sel         = SEL_SEQ;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        if (rst) begin
            w_next_pc     = '0;
            w_sel         = SEL_RESET;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (!hold) begin
            if (w_misp) begin
                w_next_pc     = w_misp_tgt;
                w_sel         = SEL_MISP;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end else if (r_state == ST_PEND) begin
                w_next_pc     = r_pend_tgt;
                w_sel         = SEL_PEND;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = r_pend_misp;
            end else if (jr_D) begin
                w_next_pc     = jr_addr_D;
                w_sel         = SEL_JR;
                w_flush_if_id = 1'b1;
            end else if (jump_F) begin
                w_next_pc = jump_addr_F;
                w_sel     = SEL_JUMP;
            end else if (branch_F && prediction_F) begin
                w_next_pc = branch_addr_F;
                w_sel     = SEL_PRED;
            end
        end
    end

    // A stored JR may be refreshed by a newer JR or replaced by a misp; a stored
    // MISP is only ever replaced by a newer misp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pend_tgt  <= '0;
            r_pend_misp <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (hold && (w_misp || jr_D)) begin
                        r_state     <= ST_PEND;
                        r_pend_tgt  <= w_misp ? w_misp_tgt : jr_addr_D;
                        r_pend_misp <= w_misp;
                    end
                end
                ST_PEND: begin
                    if (!hold) begin
                        r_state     <= ST_RUN;
                        r_pend_misp <= 1'b0;
                    end else if (w_misp) begin
                        r_pend_tgt  <= w_misp_tgt;
                        r_pend_misp <= 1'b1;
                    end else if (jr_D && !r_pend_misp) begin
                        r_pend_tgt  <= jr_addr_D;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // A misp parked in PEND is counted when it is finally applied.
    assign w_br_inc   = ~hold & branch_EX;
    assign w_misp_inc = ~hold & (w_misp | ((r_state == ST_PEND) & r_pend_misp));

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_en    (w_br_inc),
        .o_count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_misp_cnt (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_en    (w_misp_inc),
        .o_count (mispredict_count)
    );

    assign next_pc          = w_next_pc;
    assign pc_sel           = w_sel;
    assign flush_IF_ID      = w_flush_if_id;
    assign flush_ID_EX      = w_flush_id_ex;
    assign redirect_pending = (r_state == ST_PEND);

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequences the fetch-stage PC source. It arbitrates redirect requests in priority order: EX misprediction recovery, jr from decode, direct jump in fetch, predicted-taken branch in fetch, and sequential PC+1. It produces next_pc for the program counter plus one-cycle flush strobes for the IF/ID and ID/EX registers. A redirect that arrives while hold is asserted is held pending and applied on the first non-held cycle. Two saturating performance counters track resolved branches and mispredictions.

Parameters:
PC_W, 10, PC and instruction-address width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
hold  in  1  fetch stall; PC must not advance
pc_plus1_F  in  PC_W  sequential fetch PC+1
branch_F  in  1  beq/bne decoded in fetch
prediction_F  in  1  BPU taken prediction for branch_F
branch_addr_F  in  PC_W  fetch branch target
jump_F  in  1  j/jal decoded in fetch
jump_addr_F  in  PC_W  direct jump target
jr_D  in  1  jr resolved in decode
jr_addr_D  in  PC_W  register target
branch_EX  in  1  branch resolving in EX this cycle
prediction_EX  in  1  prediction carried with the EX branch
taken_EX  in  1  actual outcome
branch_addr_EX  in  PC_W  EX branch target
pc_plus1_EX  in  PC_W  EX fall-through address
next_pc  out  PC_W  value for the PC register
pc_sel  out  3  0 SEQ, 1 PRED, 2 JUMP, 3 JR, 4 MISP, 5 PEND, 7 RESET
flush_IF_ID  out  1  squash IF/ID on this edge
flush_ID_EX  out  1  squash ID/EX on this edge
redirect_pending  out  1  pending redirect stored
branch_count  out  CNT_W  resolved branches
mispredict_count  out  CNT_W  mispredictions

Behaviour:
- Mispredict condition: misp = branch_EX & (prediction_EX ^ taken_EX). Recovery target is taken_EX ? branch_addr_EX : pc_plus1_EX.
- Live priority, highest first: misp > jr_D > jump_F > (branch_F & prediction_F) > SEQ.
- FSM state RUN:
  - hold=0: next_pc and pc_sel come from the live winner. Output is combinational in the same cycle.
  - hold=1 with misp or jr_D: capture target and source (MISP/JR) into the pending register and go to PEND. Outputs show pc_sel=SEQ and next_pc=pc_plus1_F; the PC ignores them under hold. No flush.
  - hold=1 with jump/pred/seq only: nothing is stored. These are recomputed from the frozen fetch instruction.
- FSM state PEND:
  - hold=1: a new misp overwrites a stored JR. A new misp overwrites a stored MISP (newest EX wins). jr_D never overwrites a stored MISP.
  - hold=0 with live misp: the live misp wins and the pending entry is discarded. Otherwise next_pc is the pending target and pc_sel=PEND. Return to RUN in both cases.
- Flush strobes are combinational and asserted only on non-held cycles:
  - MISP, or PEND holding a MISP: flush_IF_ID=1 and flush_ID_EX=1.
  - JR, or PEND holding a JR: flush_IF_ID=1 only.
  - JUMP, PRED, SEQ: no flush.
- redirect_pending = (state==PEND).
- Counters: branch_count increments on any branch_EX cycle with hold=0. mispredict_count increments on misp with hold=0. Both saturate at all-ones with no wrap. Under hold, a misp is counted once, when it is applied (including via PEND).
- Reset: while rst=1, next_pc=0, pc_sel=7, both flushes=1, state=RUN, pending cleared, counters=0. Reset asserted in PEND drops the pending redirect. The first cycle after reset behaves as RUN.
- Width: all PC arithmetic is done upstream; this block only selects. Counters are unsigned.

Decomposition:
- Shared package fetch_pkg holds:
  - PC_W, CNT_W defaults
  - pc_sel encodings SEL_SEQ, SEL_PRED, SEL_JUMP, SEL_JR, SEL_MISP, SEL_PEND, SEL_RESET
  - FSM state encoding ST_RUN, ST_PEND
- One sub-module, sat_counter (parameterised width, synchronous clear, enable), instantiated twice.

Test Plan:
- Reset: rst=1 for 2 cycles -> next_pc=0, pc_sel=7, flushes=1, counters 0. Release -> pc_plus1_F=0x001 gives next_pc=0x001, pc_sel=0.
- Priority: misp (prediction_EX=1, taken_EX=0, pc_plus1_EX=0x020) together with jr_D (0x055), jump_F (0x100) and predicted branch_F (0x0C0) -> next_pc=0x020, pc_sel=4, both flushes=1, mispredict_count=1, branch_count=1.
- Jump only: jump_F with jump_addr_F=0x3FF, hold=0 -> next_pc=0x3FF, pc_sel=2, no flush. Adding predicted branch_F the same cycle changes nothing.
- Held JR: hold=1 with jr_D=1, jr_addr_D=0x0AA -> redirect_pending=1 and no flush. hold stays 1 for 3 cycles, then drops -> next_pc=0x0AA, pc_sel=5, flush_IF_ID=1, flush_ID_EX=0, pending cleared the next cycle.
- PEND overwrite:
  - Stored JR, then misp under hold (taken_EX=1, branch_addr_EX=0x011) -> on release next_pc=0x011, both flushes=1, mispredict_count incremented by exactly 1.
  - Stored MISP, then jr_D under hold -> on release next_pc is the stored MISP target; jr_D does not replace it.
- Saturation and reset in PEND: preload with CNT_W=4 and drive 20 mispredicts -> both counters hold 0xF. rst asserted while in PEND -> pending cleared and counters reset to 0.
